// File: rtl/oam_dma_if.sv
// -----------------------------------------------------------------------------
// oam_dma_if -- CPU-side and memory-bus-side signal bundle for oam_dma.
//
// Signals
//   ce      CPU-cycle enable (advance only on edges where ce=1)
//   cpu_a   CPU address bus            cpu_d   CPU write data
//   cpu_r   CPU read strobe            cpu_w   CPU write strobe
//   cpu_ce  gated enable back to the CPU (ce & ~busy)
//   bus_a   memory address             bus_d   memory write data
//   bus_i   memory read data           bus_r   memory read strobe
//   bus_w   memory write strobe        busy    DMA transfer in progress
//
// Modports
//   slave   the DMA block itself (consumes CPU signals, drives the bus)
//   master  the surroundings (CPU, memory model, testbench)
// -----------------------------------------------------------------------------
interface oam_dma_if;
  logic        ce;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_r;
  logic        cpu_w;
  logic        cpu_ce;
  logic [15:0] bus_a;
  logic [7:0]  bus_i;
  logic [7:0]  bus_d;
  logic        bus_r;
  logic        bus_w;
  logic        busy;

  modport slave (
    input  ce, cpu_a, cpu_d, cpu_r, cpu_w, bus_i,
    output cpu_ce, bus_a, bus_d, bus_r, bus_w, busy
  );

  modport master (
    output ce, cpu_a, cpu_d, cpu_r, cpu_w, bus_i,
    input  cpu_ce, bus_a, bus_d, bus_r, bus_w, busy
  );
endinterface

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma -- sprite-attribute DMA engine.
//
// A CPU write to $4014 latches a source page and stalls the CPU while the
// block copies the 256 bytes {page,00}..{page,FF} one by one into the OAM
// data port at $2004 (READ cycle, then WRITE cycle, per byte).
//
// Ports
//   clock   system clock, all state changes on the rising edge
//   reset   asynchronous, active-high
//   io      oam_dma_if.slave: ce, CPU bus in, memory bus out, cpu_ce, busy
//
// Build option
//   OAM_DMA_ALIGN_EN  when defined, a HALT that lands on an odd CPU cycle is
//                     followed by one idle ALIGN cycle (514 busy cycles);
//                     when undefined the transfer is always 513 busy cycles.
// -----------------------------------------------------------------------------
module oam_dma (
  input  logic      clock,
  input  logic      reset,
  oam_dma_if.slave  io
);

  localparam logic [15:0] TRIGGER_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  page_q,  page_d;
  logic [7:0]  idx_q,   idx_d;
  logic [7:0]  dma_d_q, dma_d_d;
  logic        odd_q,   odd_d;

  logic        busy;
  logic        trigger;

  assign busy    = (state_q != S_IDLE);
  assign trigger = io.cpu_w && (io.cpu_a == TRIGGER_ADDR);

  // ---------------------------------------------------------------------------
  // Next-state logic. Nothing moves on ce=0 edges.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    dma_d_d = dma_d_q;
    odd_d   = odd_q;

    if (io.ce) begin
      // CPU cycle parity runs freely, whether or not a transfer is active.
      odd_d = ~odd_q;

      unique case (state_q)
        S_IDLE: begin
          if (trigger) begin
            page_d  = io.cpu_d;
            state_d = S_HALT;
          end
        end

        S_HALT: begin
          idx_d = 8'h00;
`ifdef OAM_DMA_ALIGN_EN
          // Reads must start on an even CPU cycle; burn one cycle if odd.
          state_d = odd_q ? S_ALIGN : S_READ;
`else
          state_d = S_READ;
`endif
        end

        S_ALIGN: state_d = S_READ;

        S_READ: begin
          // Memory data for {page,idx} is captured on the edge leaving READ.
          dma_d_d = io.bus_i;
          state_d = S_WRITE;
        end

        S_WRITE: begin
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    if (reset) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      dma_d_q <= 8'h00;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      dma_d_q <= dma_d_d;
      odd_q   <= odd_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus multiplexing. Idle: the CPU owns the bus untouched (including the
  // trigger write itself). Busy: DMA owns it, strobes qualified by ce so a
  // stretched cycle produces exactly one access.
  // ---------------------------------------------------------------------------
  always_comb begin
    io.busy   = busy;
    io.cpu_ce = io.ce & ~busy;
    io.bus_a  = io.cpu_a;
    io.bus_d  = io.cpu_d;
    io.bus_r  = io.cpu_r;
    io.bus_w  = io.cpu_w;

    if (busy) begin
      io.bus_a = (state_q == S_WRITE) ? OAM_DATA_ADDR : {page_q, idx_q};
      io.bus_d = dma_d_q;
      io.bus_r = io.ce && (state_q == S_READ);
      io.bus_w = io.ce && (state_q == S_WRITE);
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma -- self-checking bench for oam_dma.
//
// The reference model is a byte-level description of a transfer: given a
// page and the CPU-cycle parity at HALT, it predicts the list of source
// addresses read, the list of bytes written to $2004 (taken from the bench's
// memory image), the number of busy ce cycles and the ce cycle of the first
// read. Bus activity is collected once per cycle and compared afterwards.
// -----------------------------------------------------------------------------
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;

  oam_dma_if dif ();

  oam_dma dut (
    .clock (clock),
    .reset (reset),
    .io    (dif.slave)
  );

  always #20 clock = ~clock;   // 25 MHz

  // Memory image; read data follows the address within the same cycle.
  logic [7:0] mem [0:65535];
  assign dif.bus_i = mem[dif.bus_a];

  int checks   = 0;
  int errors   = 0;
  int ce_edges = 0;            // ce=1 edges since reset released

  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];
  int          busy_cnt;
  int          first_rd;
  bit          logging;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle rules plus logging of DMA traffic. Called away from the edge.
  task automatic observe();
    logic exp_cpu_ce;
    exp_cpu_ce = dif.ce & ~dif.busy;
    check("cpu_ce", 32'(dif.cpu_ce), 32'(exp_cpu_ce));
    if (!dif.busy) begin
      check("idle_bus_a", 32'(dif.bus_a), 32'(dif.cpu_a));
      check("idle_bus_d", 32'(dif.bus_d), 32'(dif.cpu_d));
      check("idle_bus_r", 32'(dif.bus_r), 32'(dif.cpu_r));
      check("idle_bus_w", 32'(dif.bus_w), 32'(dif.cpu_w));
    end else begin
      check("strobe_excl", 32'(dif.bus_r & dif.bus_w), 32'd0);
      if (!dif.ce)
        check("strobe_no_ce", 32'(dif.bus_r | dif.bus_w), 32'd0);
      if (logging && dif.ce) begin
        busy_cnt++;
        if (dif.bus_r) begin
          rd_q.push_back(dif.bus_a);
          if (first_rd == 0) first_rd = busy_cnt;
        end
        if (dif.bus_w) begin
          check("wr_addr", 32'(dif.bus_a), 32'h2004);
          wr_q.push_back(dif.bus_d);
        end
      end
    end
  endtask

  task automatic step(input bit ce_v, input bit w, input bit r,
                      input logic [15:0] a, input logic [7:0] d);
    dif.ce    = ce_v;
    dif.cpu_w = w;
    dif.cpu_r = r;
    dif.cpu_a = a;
    dif.cpu_d = d;
    @(negedge clock);
    observe();
    @(posedge clock);
    if (ce_v && !reset) ce_edges++;
    #1;
  endtask

  task automatic do_reset();
    dif.ce    = 1'b0;
    dif.cpu_w = 1'b0;
    dif.cpu_r = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    ce_edges = 0;
  endtask

  // One complete (or aborted) transfer from `page`. want_odd selects the CPU
  // cycle parity at the HALT edge; slow gives ce roughly 1/3 duty; a nonzero
  // abort_after asserts reset once that many bytes have been written.
  task automatic run_xfer(input logic [7:0] page, input bit want_odd,
                          input bit slow, input int abort_after);
    int  exp_cycles, exp_first, n_exp;
    bit  done, aborted, ce_v;
    logic [15:0] a;

    // Parity at HALT = parity of ce edges before it = (edges now + trigger) % 2.
    if (((ce_edges + 1) % 2) != int'(want_odd)) step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    exp_cycles = 513 + ((ALIGN_EN && want_odd) ? 1 : 0);
    exp_first  = 2   + ((ALIGN_EN && want_odd) ? 1 : 0);

    rd_q.delete();
    wr_q.delete();
    busy_cnt = 0;
    first_rd = 0;
    logging  = 1'b1;
    done     = 1'b0;
    aborted  = 1'b0;

    // Trigger: the CPU's own write still reaches the bus (checked in observe).
    step(1'b1, 1'b1, 1'b0, 16'h4014, page);
    check("busy_after_trigger", 32'(dif.busy), 32'd1);

    for (int n = 0; n < 4000; n++) begin
      ce_v = slow ? ($urandom_range(0, 2) == 0) : 1'b1;
      // Stalled CPU noise, including ignored writes to $4014.
      a = ($urandom_range(0, 7) == 0) ? 16'h4014 : 16'($urandom_range(0, 16'h3FFF));
      step(ce_v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom));
      if (abort_after > 0 && wr_q.size() == abort_after) begin
        aborted = 1'b1;
        break;
      end
      if (!dif.busy) begin
        done = 1'b1;
        break;
      end
    end
    logging = 1'b0;

    if (abort_after > 0) begin
      check("abort_reached", 32'(aborted), 32'd1);
      dif.cpu_w = 1'b0;
      dif.cpu_r = 1'b0;
      #5 reset = 1'b1;
      #1;
      check("abort_busy", 32'(dif.busy), 32'd0);
      check("abort_bus_w", 32'(dif.bus_w), 32'd0);
      check("abort_bus_r", 32'(dif.bus_r), 32'd0);
      check("abort_cpu_ce", 32'(dif.cpu_ce), 32'(dif.ce));
      do_reset();
      check("abort_bytes", 32'(wr_q.size()), 32'(abort_after));
      n_exp = abort_after;
    end else begin
      check("xfer_done", 32'(done), 32'd1);
      check("busy_cycles", 32'(busy_cnt), 32'(exp_cycles));
      check("first_read", 32'(first_rd), 32'(exp_first));
      check("read_count", 32'(rd_q.size()), 32'd256);
      check("write_count", 32'(wr_q.size()), 32'd256);
      n_exp = 256;
    end

    for (int i = 0; i < n_exp && i < rd_q.size(); i++)
      check("rd_addr", 32'(rd_q[i]), 32'({page, 8'(i)}));
    for (int i = 0; i < n_exp && i < wr_q.size(); i++)
      check("wr_data", 32'(wr_q[i]), 32'(mem[{page, 8'(i)}]));
  endtask

  initial begin
    logic [7:0] pg;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)   mem[16'h0300 + i] = 8'(i);

    dif.ce    = 1'b0;
    dif.cpu_a = 16'h0000;
    dif.cpu_d = 8'h00;
    dif.cpu_r = 1'b0;
    dif.cpu_w = 1'b0;
    reset     = 1'b1;
    logging   = 1'b0;

    // Reset state: not busy, CPU passes straight through, cpu_ce follows ce.
    @(posedge clock);
    dif.ce    = 1'b1;
    dif.cpu_a = 16'h1234;
    dif.cpu_d = 8'h5A;
    dif.cpu_w = 1'b1;
    @(negedge clock);
    check("rst_busy", 32'(dif.busy), 32'd0);
    check("rst_cpu_ce", 32'(dif.cpu_ce), 32'd1);
    check("rst_bus_a", 32'(dif.bus_a), 32'h1234);
    check("rst_bus_d", 32'(dif.bus_d), 32'h5A);
    check("rst_bus_w", 32'(dif.bus_w), 32'd1);
    do_reset();

    for (int i = 0; i < 6; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 16'h3FFF)), 8'($urandom));

    // Near misses must not trigger.
    step(1'b1, 1'b1, 1'b0, 16'h4015, 8'h02);
    check("no_trig_4015", 32'(dif.busy), 32'd0);
    step(1'b1, 1'b0, 1'b1, 16'h4014, 8'h02);
    check("no_trig_rd_4014", 32'(dif.busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 16'h4014, 8'h02);
    check("no_trig_ce0", 32'(dif.busy), 32'd0);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    check("still_idle", 32'(dif.busy), 32'd0);

    run_xfer(8'h02, 1'b0, 1'b0, 0);   // even parity at HALT
    run_xfer(8'h02, 1'b1, 1'b0, 0);   // odd parity at HALT
    run_xfer(8'h03, 1'b0, 1'b1, 0);   // index pattern, stretched cycles
    run_xfer(8'h20, 1'b1, 1'b1, 0);   // PPU page, stretched, odd
    pg = 8'($urandom);
    run_xfer(pg, 1'b0, 1'b0, 100);    // reset after 100 bytes
    run_xfer(8'h05, 1'($urandom_range(0, 1)), 1'b0, 0);  // fresh start after abort

    step(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    check("final_idle", 32'(dif.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
